// File: rtl/tx_fifo_pkg.sv
// Shared definitions for the PCS TX async FIFO: default geometry and Gray-code helpers.
package tx_fifo_pkg;

    localparam int unsigned ADDRSIZE_DEF = 7;
    localparam int unsigned PTR_W_DEF    = ADDRSIZE_DEF + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational W-bit Gray-to-binary converter.
module gray2bin_n #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = gray;
        for (int unsigned i = 1; i < W; i++) begin
            bin = bin ^ (gray >> i);
        end
    end

endmodule

// File: rtl/tx_fifo_rptr_empty.sv
// Read-side pointer, empty/almost-empty, level and sticky underflow status for the PCS TX async FIFO.
module tx_fifo_rptr_empty
    import tx_fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE      = ADDRSIZE_DEF,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rclr_err,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int unsigned     PW     = ADDRSIZE + 1;
    localparam logic [PW-1:0]   THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          runderflow_q, runderflow_d;
    logic [PW-1:0] wbin_s;

    gray2bin_n #(.W(PW)) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // Status is computed on the post-pop pointer so a pop of the last word flags empty on the same edge.
    always_comb begin
        rbin_d       = rbin_q + PW'(rinc & ~rempty_q);
        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        rempty_d     = (rptr_d == rq2_wptr);
        rlevel_d     = wbin_s - rbin_d;
        raempty_d    = (rlevel_d <= THRESH);
        runderflow_d = (rinc & rempty_q) | (runderflow_q & ~rclr_err);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule
